// File: rtl/rr_arb_mux.sv
// rr_arb_mux: CHANNELS-to-1 multiplexer with a one-word registered output.
// The channel is picked by an external select (MODE=0) or by a rotating
// round-robin pointer (MODE=1). A valid/ready handshake is used on both sides.
module rr_arb_mux #(
  parameter  int WIDTH    = 4,
  parameter  int CHANNELS = 4,
  parameter  int MODE     = 1,
  localparam int SELW     = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [SELW-1:0]           sel,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SELW-1:0]           out_chan
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [SELW-1:0]   ptr_q, ptr_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic [SELW-1:0]   out_chan_q, out_chan_d;

  logic [SELW-1:0]   grant_s;
  logic              grant_valid_s;
  logic              slot_free_s;
  logic              load_s;
  logic [WIDTH-1:0]  grant_data_s;

  // Grant selection: external select, or first valid channel at/after ptr.
  always_comb begin
    grant_s       = '0;
    grant_valid_s = 1'b0;
    if (MODE == 0) begin
      // Loop compare keeps out-of-range selects from ever granting.
      for (int i = 0; i < CHANNELS; i++) begin
        if (sel == SELW'(i)) begin
          grant_s       = SELW'(i);
          grant_valid_s = in_valid[i];
        end else begin
          grant_s       = grant_s;
        end
      end
    end else begin
      // Walk backwards so the last hit written is the closest one to ptr.
      for (int k = CHANNELS - 1; k >= 0; k--) begin
        int idx;
        idx = (int'(ptr_q) + k) % CHANNELS;
        if (in_valid[idx]) begin
          grant_s       = SELW'(idx);
          grant_valid_s = 1'b1;
        end else begin
          grant_valid_s = grant_valid_s;
        end
      end
    end
  end

  // Handshake decode; reset suppresses any load in the reset cycle.
  always_comb begin
    slot_free_s = (state_q == ST_EMPTY) || out_ready;
    load_s      = enable && slot_free_s && grant_valid_s && !reset;
    in_ready    = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant_s == SELW'(i)) begin
        in_ready[i] = load_s;
      end else begin
        in_ready[i] = 1'b0;
      end
    end
  end

  // Data mux for the granted channel.
  always_comb begin
    grant_data_s = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant_s == SELW'(i)) begin
        grant_data_s = in_data[i*WIDTH +: WIDTH];
      end else begin
        grant_data_s = grant_data_s;
      end
    end
  end

  // Next-state, output register and pointer update.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    out_data_d = out_data_q;
    out_chan_d = out_chan_q;

    case (state_q)
      ST_EMPTY: begin
        if (load_s) begin
          state_d = ST_FULL;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (load_s) begin
          state_d = ST_FULL;
        end else if (out_ready) begin
          state_d = ST_EMPTY;
        end else begin
          state_d = ST_FULL;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    if (load_s) begin
      out_data_d = grant_data_s;
      out_chan_d = grant_s;
    end else begin
      out_data_d = out_data_q;
      out_chan_d = out_chan_q;
    end

    if ((MODE != 0) && load_s) begin
      if (grant_s == SELW'(CHANNELS - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = grant_s + SELW'(1);
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // State registers; reset discards any held word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_EMPTY;
      ptr_q      <= '0;
      out_data_q <= '0;
      out_chan_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      out_data_q <= out_data_d;
      out_chan_q <= out_chan_d;
    end
  end

  assign out_valid = (state_q == ST_FULL);
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;

endmodule
